if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode stage. Holds the PC and issues word fetches to
//  instruction memory (at most one outstanding). Buffers returned words with their PCs in a small FIFO.
//  Presents them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO,
//  discard any in-flight response and restart fetch at the target.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              instr/PC buffer entries (power of 2, >=2)
// PORTS
//  clk             in   1   single clock, all state on posedge
//  rstn            in   1   asynchronous active-low reset
//  imem_req        out  1   fetch request; memory accepts every asserted request
//  imem_addr       out  32  word address of request (bits[1:0]=0)
//  imem_rvalid     in   1   response valid, >=1 cycle after its request, in order
//  imem_rdata      in   32  instruction word of response
//  redirect_valid  in   1   taken branch/jal/jalr from execute, one-cycle pulse
//  redirect_pc     in   32  redirect target
//  instr_valid     out  1   FIFO head valid toward decode
//  instr           out  32  head instruction; 32'h0000_0013 (NOP) when !instr_valid
//  instr_pc        out  32  PC of head instruction; 0 when !instr_valid
//  id_ready        in   1   decode accepts head this cycle (pop when instr_valid&id_ready)
//  fetch_misalign  out  1   (IF_MISALIGN_CHK_EN only) sticky misaligned-redirect flag
// BEHAVIOUR
//  Reset (async, rstn=0): pc=RESET_PC, FIFO empty, outstanding=0, state=FETCH, fetch_misalign=0.
//   imem_req=0, instr_valid=0, instr=NOP, instr_pc=0 while in reset.
//  FSM: FETCH (may issue), WAIT (one request outstanding), DRAIN (outstanding response to discard).
//   FETCH: imem_req=1 iff (count+outstanding)<FIFO_DEPTH; on issue pc<=pc+4, ->WAIT.
//   WAIT: on imem_rvalid push {rdata, req_pc}; a new request may issue in the same cycle if space permits
//    (count after push/pop < FIFO_DEPTH) -> stays WAIT, else ->FETCH. Sustains 1 instr/cycle at 1-cycle mem.
//   DRAIN: imem_req=0; on imem_rvalid drop the data, ->FETCH.
//  Latency: first imem_req in first cycle after rstn rises, addr=RESET_PC. rvalid in cycle k gives
//   instr_valid=1 in cycle k+1 (FIFO registered).
//  Redirect (cycle N): FIFO cleared at edge N; pc<=redirect_pc; imem_req suppressed in N.
//   If a request was outstanding (and rvalid not seen in N) ->DRAIN, else ->FETCH.
//   First request to redirect_pc is issued in N+1 (no outstanding) or the cycle after the discarded rvalid.
//  Simultaneous events: redirect beats pop, push and issue in the same cycle; rvalid in cycle N is discarded.
//   Pop+push in same cycle with FIFO full is legal (count unchanged).
//  Full: no request issues while count+outstanding==FIFO_DEPTH; responses are never dropped except on redirect.
//  Empty: instr_valid=0; id_ready ignored.
//  PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 0 silently.
//  Reset mid-operation: all state cleared; a late rvalid after reset with outstanding=0 is ignored.
// CONFIGURATION
//  IF_MISALIGN_CHK_EN defined: redirect_pc[1:0]!=0 sets fetch_misalign (sticky until reset).
//   The redirect is still taken with bits[1:0] forced to 0.
//  Undefined: port absent; redirect_pc[1:0] silently forced to 0.
// STRUCTURE
//  Shared defines header (src/params/if_defs.vh): NOP_INSTR 32'h0000_0013, FSM state encodings
//   (FETCH=2'd0, WAIT=2'd1, DRAIN=2'd2), default RESET_PC.
//  Sub-module instr_fifo: sync FIFO, width 64 ({pc,instr}), depth FIFO_DEPTH, push/pop/clear.
//   Count, async-reset pointers. Top handles FSM, PC and handshakes.
// TESTING
//  1 Reset release, 1-cycle mem, id_ready=1: imem_addr 0,4,8,... on consecutive cycles.
//    instr_valid from cycle 2 with instr_pc 0,4,8; no bubbles.
//  2 id_ready=0 for 6 cycles: at most FIFO_DEPTH fetches (addr 0,4), then imem_req=0.
//    On release, PCs 0,4,8 delivered in order, none lost or duplicated.
//  3 3-cycle mem latency, redirect_valid with redirect_pc=32'h100 while request outstanding:
//    stale rvalid dropped, next imem_addr=32'h100, next instr_pc=32'h100.
//  4 redirect_valid, imem_rvalid and id_ready in same cycle with FIFO holding 2 entries:
//    FIFO empty next cycle, returned word never appears; fetch restarts at target.
//  5 rstn pulled low mid-WAIT: outputs at reset values immediately; after release fetch restarts at RESET_PC.
//    Late rvalid ignored.
//  6 (IF_MISALIGN_CHK_EN) redirect_pc=32'h0000_0102: fetch_misalign=1 and stays 1; imem_addr=32'h100.
//    Without the macro, same addr and no flag port.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional feature macro used by the stage: IF_MISALIGN_CHK_EN.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_instr_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs for the decode stage.
// Power-of-two depth; clear empties it in one cycle.
module if_fetch_unit_instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage write; entries need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem fetch, buffer to decode.
// Define IF_MISALIGN_CHK_EN to add the sticky fetch_misalign flag output.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        id_ready
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic [CW-1:0] count;
    logic [CW:0]  cnt_after;
    logic [63:0]  wr_word;
    logic [63:0]  rd_word;
    fetch_entry_t head;
    logic         push;
    logic         pop;
    logic         issue;
    logic         wait_push;

    assign head        = fetch_entry_t'(rd_word);
    assign wr_word     = {req_pc_q, imem_rdata};
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc : 32'h0;
    assign pop         = instr_valid && id_ready && !redirect_valid;
    assign wait_push   = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign cnt_after   = {1'b0, count}
                       + {{CW{1'b0}}, wait_push}
                       - {{CW{1'b0}}, pop};
    assign imem_req    = issue;
    assign imem_addr   = pc_q;

    if_fetch_unit_instr_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .wdata (wr_word),
        .rdata (rd_word),
        .count (count)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Next state; a redirect leaves a drain state only if a reply is still due
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (state_q != ST_FETCH && !imem_rvalid)
                state_d = ST_DRAIN;
            else
                state_d = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_FETCH: if (issue) state_d = ST_WAIT;
                ST_WAIT:  if (imem_rvalid)
                              state_d = issue ? ST_WAIT : ST_FETCH;
                ST_DRAIN: if (imem_rvalid) state_d = ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    // Issue/push decisions; redirect and reset suppress both
    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        unique case (state_q)
            ST_FETCH: issue = ({1'b0, count} < DEPTH_W);
            ST_WAIT: begin
                push  = imem_rvalid;
                issue = imem_rvalid && (cnt_after < DEPTH_W);
            end
            ST_DRAIN: ;
            default: ;
        endcase
        if (redirect_valid || !rstn) begin
            issue = 1'b0;
            push  = 1'b0;
        end
    end

    // Fetch PC and PC of the in-flight request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= word_align(redirect_pc);
        end else if (issue) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    // Sticky flag for a redirect target with nonzero low bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            fetch_misalign <= 1'b0;
        else if (redirect_valid && redirect_pc[1:0] != 2'b00)
            fetch_misalign <= 1'b1;
    end
`endif

endmodule
